// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Stall / bubble / freeze / flush sequencer for a 5-stage MIPS pipeline.
//   Branches and JR resolve in ID, and ID only sees the EX/MEM ALU result
//   through forwarding. An instruction in ID that depends on a result that is
//   not yet available is held there for 1 or 2 cycles while bubbles enter ID/EX.
//   The whole pipeline freezes while a load in MEM waits for the data memory.
//   Taken control transfers flush IF/ID.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   id_*                  instruction in ID: valid, source fields/usage, branch, taken
//   id_ex_*               EX-stage RegWrite / MemRead / destination register
//   ex_mem_*              MEM-stage RegWrite / MemRead / destination register
//   mem_ready             data memory finished the access in MEM
//   PC_Write, IF_ID_Write PC and IF/ID enables
//   IF_ID_Flush           clear IF/ID on the next edge
//   ID_EX_Bubble          insert zeroed control into ID/EX
//   Pipe_Write            ID/EX, EX/MEM, MEM/WB enable
//   stall_active          registered state is STALL
//   stall_cycles          saturating count of cycles with PC_Write = 0
module hazard_stall_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_taken,
  input  logic              id_ex_RegWrite,
  input  logic              id_ex_MemRead,
  input  logic [4:0]        id_ex_write_addr,
  input  logic              ex_mem_RegWrite,
  input  logic              ex_mem_MemRead,
  input  logic [4:0]        ex_mem_write_addr,
  input  logic              mem_ready,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Bubble,
  output logic              Pipe_Write,
  output logic              stall_active,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  logic [1:0] n_rs, n_rt, n_req;
  logic       freeze;

  function automatic logic stage_match(input logic used, input logic [4:0] src,
                                       input logic reg_write, input logic [4:0] waddr);
    return used & reg_write & (waddr != 5'd0) & (waddr == src);
  endfunction

  // Cycles a single source must wait before the ID-stage consumer can see it.
  function automatic logic [1:0] src_need(input logic ex_hit, input logic ex_load,
                                          input logic mem_hit, input logic mem_load,
                                          input logic branch);
    logic [1:0] n;
    n = 2'd0;
    if (ex_hit && ex_load)        n = branch ? 2'd2 : 2'd1;
    else if (ex_hit)              n = branch ? 2'd1 : 2'd0;
    else if (mem_hit && mem_load) n = branch ? 2'd1 : 2'd0;
    return n;
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    n_rs = src_need(stage_match(id_uses_rs, id_rs_addr, id_ex_RegWrite, id_ex_write_addr),
                    id_ex_MemRead,
                    stage_match(id_uses_rs, id_rs_addr, ex_mem_RegWrite, ex_mem_write_addr),
                    ex_mem_MemRead, id_is_branch);
    n_rt = src_need(stage_match(id_uses_rt, id_rt_addr, id_ex_RegWrite, id_ex_write_addr),
                    id_ex_MemRead,
                    stage_match(id_uses_rt, id_rt_addr, ex_mem_RegWrite, ex_mem_write_addr),
                    ex_mem_MemRead, id_is_branch);
    n_req = 2'd0;
    if (id_valid) n_req = (n_rs > n_rt) ? n_rs : n_rt;
  end

  assign freeze = ex_mem_MemRead & ~mem_ready;

  always_comb begin
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Write   = 1'b0;
    state_next   = state;
    cnt_next     = cnt;
    // Reset forces every enable low; freeze keeps everything held.
    if (!reset && !freeze) begin
      if (state == STALL) begin
        ID_EX_Bubble = 1'b1;
        Pipe_Write   = 1'b1;
        cnt_next     = cnt - 2'd1;
        if (cnt_next == 2'd0) state_next = RUN;
      end else if (n_req == 2'd0) begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        Pipe_Write  = 1'b1;
        IF_ID_Flush = id_valid & id_taken;
      end else begin
        // id_taken is not trusted here: operands are not ready yet.
        ID_EX_Bubble = 1'b1;
        Pipe_Write   = 1'b1;
        if (n_req == 2'd2) begin
          state_next = STALL;
          cnt_next   = 2'd1;
        end
      end
    end
  end

  assign stall_active = (state == STALL) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      cnt          <= 2'd0;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (!PC_Write) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule
